// File: rtl/adc_sample_packer_pkg.sv
// Shared constants, state encoding and sample conversion for the ADC sample packer.
package adc_pkg;

  localparam int ADC_W    = 10;
  localparam int SAMPLE_W = 16;
  localparam logic [ADC_W-1:0] ADC_MIDSCALE = 10'd512;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    DRAIN  = ST_DRAIN
  } state_t;

  // Offset-binary to two's complement, then left-justify into the output word.
  function automatic logic [SAMPLE_W-1:0] toSigned(input logic [ADC_W-1:0] sample);
    logic [ADC_W-1:0] centred;
    centred = sample - ADC_MIDSCALE;
    return {centred, {(SAMPLE_W-ADC_W){1'b0}}};
  endfunction

endpackage

// File: rtl/adc_sample_packer_if.sv
// Output stream toward the USB/GPIF transfer stage: show-ahead data with valid/ready.
interface adc_sample_packer_if;
  import adc_pkg::*;

  logic [SAMPLE_W-1:0] outData;
  logic                outValid;
  logic                outReady;

  modport master (output outData, output outValid, input outReady);
  modport slave  (input outData, input outValid, output outReady);
endinterface

// File: rtl/adc_sample_packer_sync_fifo.sv
// Single-clock show-ahead FIFO. The extra pointer bit separates full from empty;
// a push into a full FIFO is refused unless a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              push,
  input  logic [DATA_W-1:0] wrData,
  input  logic              pop,
  output logic [DATA_W-1:0] rdData,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wrPtr, rdPtr;
  logic              doPush, doPop;

  assign level  = wrPtr - rdPtr;
  assign full   = level[ADDR_W];
  assign empty  = (level == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  // Head word is forced to zero while empty so the output is never undefined.
  assign rdData = empty ? '0 : mem[rdPtr[ADDR_W-1:0]];

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage array; contents are only visible through the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr[ADDR_W-1:0]] <= wrData;
  end

endmodule

// File: rtl/adc_sample_packer.sv
// ADC sample packer: converts 10-bit unsigned samples to left-justified signed words,
// buffers them and streams them out, with capture gating and dropped-sample accounting.
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic [ADC_W-1:0]     adcData,
  input  logic                 collect,
  adc_sample_packer_if.master  outBus,
  output logic [ADDR_W:0]      fifoLevel,
  output logic                 overflow,
  output logic [CNT_W-1:0]     droppedCount,
  output logic                 busy
);

  state_t              state, nextState;
  logic [SAMPLE_W-1:0] convReg;
  logic                convValid;
  logic                fifoFull, fifoEmpty;
  logic                pop, drop;

  assign outBus.outValid = !fifoEmpty;
  assign pop  = !fifoEmpty && outBus.outReady;
  // A pending word is lost only when the FIFO is full and nothing leaves this edge.
  assign drop = convValid && fifoFull && !pop;
  assign busy = (state != IDLE);

  sync_fifo #(.DATA_W(SAMPLE_W), .ADDR_W(ADDR_W)) uFifo (
    .clock  (clock),
    .nReset (nReset),
    .push   (convValid),
    .wrData (convReg),
    .pop    (pop),
    .rdData (outBus.outData),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .level  (fifoLevel)
  );

  // State register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic; a re-asserted collect in DRAIN resumes streaming with the FIFO intact.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (collect) nextState = STREAM;
      STREAM:  if (!collect) nextState = DRAIN;
      DRAIN: begin
        if (collect)                      nextState = STREAM;
        else if (fifoEmpty && !convValid) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Conversion register; the sample on the edge that leaves STREAM is not captured.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      convReg   <= '0;
      convValid <= 1'b0;
    end else begin
      convReg   <= toSigned(adcData);
      convValid <= (state == STREAM) && collect;
    end
  end

  // Overflow flag and saturating drop counter, cleared as IDLE is entered.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      overflow     <= 1'b0;
      droppedCount <= '0;
    end else if (nextState == IDLE) begin
      overflow     <= 1'b0;
      droppedCount <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (droppedCount != '1) droppedCount <= droppedCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Randomised and directed bench for adc_sample_packer against a queue-based reference model.
module tb_adc_sample_packer;
  import adc_pkg::*;

  localparam int DEPTH = 256;

  logic       clock = 1'b0;
  logic       nReset = 1'b0;
  logic [9:0] adcData = '0;
  logic       collect = 1'b0;
  logic [8:0] fifoLevel;
  logic       overflow;
  logic [15:0] droppedCount;
  logic       busy;

  adc_sample_packer_if bus ();

  adc_sample_packer #(.ADDR_W(8), .CNT_W(16)) dut (
    .clock        (clock),
    .nReset       (nReset),
    .adcData      (adcData),
    .collect      (collect),
    .outBus       (bus.master),
    .fifoLevel    (fifoLevel),
    .overflow     (overflow),
    .droppedCount (droppedCount),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO as a queue, one pending converted word, mode 0/1/2 = idle/stream/drain.
  int mQ[$];
  int mPend;
  bit mPendV;
  int mMode;
  bit mOvf;
  int mDrop;

  function automatic int conv(input int s);
    int v;
    v = (s - 512) * 64;
    return v & 32'h0000FFFF;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPendV = 0;
    mPend  = 0;
    mMode  = 0;
    mOvf   = 0;
    mDrop  = 0;
  endtask

  task automatic modelStep(input bit c, input bit r, input int a);
    int pre;
    bit popped;
    int nxt;
    pre    = mQ.size();
    popped = (pre > 0) && r;
    if (popped) void'(mQ.pop_front());
    if (mPendV) begin
      if (pre < DEPTH || popped) mQ.push_back(mPend);
      else begin
        mOvf = 1;
        if (mDrop < 65535) mDrop++;
      end
    end
    nxt = mMode;
    if (mMode == 0)      nxt = c ? 1 : 0;
    else if (mMode == 1) nxt = c ? 1 : 2;
    else                 nxt = c ? 1 : ((pre == 0 && !mPendV) ? 0 : 2);
    mPendV = (mMode == 1) && c;
    mPend  = conv(a);
    if (nxt == 0) begin
      mOvf  = 0;
      mDrop = 0;
    end
    mMode = nxt;
  endtask

  task automatic compareAll();
    chk("outValid", int'(bus.outValid), (mQ.size() > 0) ? 1 : 0);
    if (mQ.size() > 0) chk("outData", int'(bus.outData), mQ[0]);
    chk("fifoLevel", int'(fifoLevel), mQ.size());
    chk("overflow", int'(overflow), int'(mOvf));
    chk("droppedCount", int'(droppedCount), mDrop);
    chk("busy", int'(busy), (mMode != 0) ? 1 : 0);
  endtask

  task automatic cycle(input bit c, input bit r, input int a);
    collect      = c;
    bus.outReady = r;
    adcData      = a[9:0];
    @(posedge clock);
    modelStep(c, r, a);
    #1;
    compareAll();
  endtask

  int cornerIn[5]  = '{0, 511, 512, 513, 1023};
  int cornerExp[5] = '{32'h8000, 32'hFFC0, 32'h0000, 32'h0040, 32'h7FC0};
  int savedDrop;
  int savedHead;
  bit c;

  initial begin
    bus.outReady = 1'b0;
    modelReset();
    #12;
    chk("rst_valid", int'(bus.outValid), 0);
    chk("rst_data", int'(bus.outData), 0);
    chk("rst_level", int'(fifoLevel), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_drop", int'(droppedCount), 0);
    chk("rst_busy", int'(busy), 0);
    nReset = 1'b1;

    // Ramp with the sink always ready.
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, (i == 0) ? 0 : i - 1);
      if (i == 1) chk("lat_lo", int'(bus.outValid), 0);
      if (i == 2) begin
        chk("lat_hi", int'(bus.outValid), 1);
        chk("first_word", int'(bus.outData), 32'h8000);
      end
      if (i == 3) chk("second_word", int'(bus.outData), 32'h8040);
    end
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);

    // Conversion corners, buffered then read out.
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, cornerIn[i]);
    cycle(0, 0, 0);
    chk("corner_level", int'(fifoLevel), 5);
    for (int i = 0; i < 5; i++) begin
      chk("corner", int'(bus.outData), cornerExp[i]);
      cycle(0, 1, 0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);

    // Fill past capacity with the sink stalled.
    for (int i = 0; i < DEPTH + 10; i++) cycle(1, 0, $urandom_range(0, 1023));
    chk("full_level", int'(fifoLevel), 256);
    chk("full_ovf", int'(overflow), 1);
    savedHead = int'(bus.outData);
    cycle(1, 0, $urandom_range(0, 1023));
    chk("stall_stable", int'(bus.outData), savedHead);

    // Full FIFO with ready and collect together: push+pop, no more drops.
    savedDrop = mDrop;
    for (int i = 0; i < 10; i++) cycle(1, 1, $urandom_range(0, 1023));
    chk("pp_level", int'(fifoLevel), 256);
    chk("pp_drop_hold", int'(droppedCount), savedDrop);

    // Drain to idle; counters clear on entry.
    for (int k = 0; k < 700 && mMode != 0; k++) cycle(0, 1, 0);
    chk("drain_idle", int'(busy), 0);
    chk("idle_ovf", int'(overflow), 0);
    chk("idle_drop", int'(droppedCount), 0);

    // Twenty words buffered, stop, resume during drain, then empty.
    for (int i = 0; i < 21; i++) cycle(1, 0, $urandom_range(0, 1023));
    cycle(0, 0, 0);
    chk("drain20_level", int'(fifoLevel), 20);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    chk("drain20_busy", int'(busy), 1);
    for (int i = 0; i < 6; i++) cycle(1, $urandom_range(0, 1), $urandom_range(0, 1023));
    for (int k = 0; k < 200 && mMode != 0; k++) cycle(0, $urandom_range(0, 1), 0);
    chk("resume_idle", int'(busy), 0);

    // Asynchronous reset with a partly full FIFO.
    for (int i = 0; i < 102; i++) cycle(1, 0, $urandom_range(0, 1023));
    chk("pre_rst_level", int'(fifoLevel), 100);
    #3;
    nReset = 1'b0;
    #1;
    chk("arst_valid", int'(bus.outValid), 0);
    chk("arst_data", int'(bus.outData), 0);
    chk("arst_level", int'(fifoLevel), 0);
    chk("arst_busy", int'(busy), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    modelReset();
    nReset = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1, 1, i);

    // Random traffic.
    c = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) c = !c;
      cycle(c, $urandom_range(0, 9) < 7, $urandom_range(0, 1023));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
